// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its arbiter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } sched_state_e;

   localparam int DATA_W_DEFAULT = 8;

   // Grant index width; a two-requester system still needs one bit.
   function automatic int gid_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int GID_W = gid_w(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GID_W-1:0] ptr,
   output logic             any,
   output logic [NREQ-1:0]  gnt,
   output logic [GID_W-1:0] idx
);

   always_comb begin
      int j;
      logic [GID_W-1:0] jj;
      any = 1'b0;
      gnt = '0;
      idx = '0;
      j   = 0;
      jj  = '0;
      // Scan from the far end so the nearest request above ptr is written last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = GID_W'(j);
         if (req[jj]) begin
            any     = 1'b1;
            gnt     = '0;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART tx serializer among NREQ byte producers,
// one frame per grant, with start timeout and a programmable inter-frame gap.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NREQ          = 2,
   parameter int DATA_W        = DATA_W_DEFAULT,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 64,
   parameter int GID_W         = gid_w(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        ack,
   output logic                   tx_start,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_busy,
   output logic [GID_W-1:0]       grant_id,
   output logic                   sched_busy,
   output logic                   timeout_err
);

   localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   sched_state_e        state_q;
   logic [GID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [NREQ-1:0]     ack_q;
   logic                tx_start_q, timeout_err_q, tx_busy_q;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [GID_W-1:0]    grant_id_q;

   logic                arb_any;
   logic [NREQ-1:0]     arb_gnt;
   logic [GID_W-1:0]    arb_idx;

   rr_arbiter #(.NREQ(NREQ), .GID_W(GID_W)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .any (arb_any),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign ptr_d     = (arb_idx == GID_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
   assign tx_data_d = req_data[arb_idx*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         ack_q         <= '0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_busy_q     <= 1'b0;
         tx_data_q     <= '0;
         grant_id_q    <= '0;
      end else begin
         ack_q         <= '0;
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         tx_busy_q     <= tx_busy;
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  tx_data_q  <= tx_data_d;
                  grant_id_q <= arb_idx;
                  ack_q      <= arb_gnt;
                  ptr_q      <= ptr_d;
                  state_q    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               tx_start_q <= 1'b1;
               cnt_q      <= START_LOAD;
               state_q    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               // Only a fresh rising edge counts; busy left over from foreign traffic does not.
               if (tx_busy && !tx_busy_q) begin
                  state_q <= ST_WAIT_DONE;
               end else if (cnt_q == '0) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (GAP_CYCLES == 0) begin
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= GAP_LOAD;
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_q == '0) state_q <= ST_IDLE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack         = ack_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign sched_busy  = (state_q != ST_IDLE);
   assign timeout_err = timeout_err_q;

endmodule
